// File: rtl/imem_pkg.sv
// Shared instruction-memory parameters and loader state encoding.
// Used by the boot loader and by the instruction memory itself.
package imem_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DEPTH  = 1024;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed big-endian byte stream into
// sequential 16-bit instruction memory writes, core held meanwhile.
import imem_pkg::*;

module imem_loader #(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] DEPTH17 = 17'(DEPTH);

    loader_state_t     state;
    logic [15:0]       len;
    logic [ADDR_W:0]   cnt;
    logic              hs;
    logic              kill;
    logic [15:0]       n_new;
    logic [16:0]       cnt_nx;

    assign hs     = byte_valid && byte_ready;
    assign n_new  = {len[15:8], byte_data};
    assign cnt_nx = 17'(cnt) + 17'd1;

    // abort only bites while a load is genuinely in flight
    assign kill = abort && (state != IDLE) && (state != DONE);

    assign byte_ready = (state == LEN_HI) || (state == LEN_LO) ||
                        (state == DATA_HI) || (state == DATA_LO);
    assign busy       = (state != IDLE);
    assign cpu_hold   = busy;
    assign done       = (state == DONE);
    assign imem_we    = (state == WRITE) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len        <= '0;
            cnt        <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            error      <= 1'b0;
        end else if (kill) begin
            state <= IDLE;
            error <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LEN_HI;
                        error     <= 1'b0;
                        cnt       <= '0;
                        imem_addr <= '0;
                    end
                end
                LEN_HI: begin
                    if (hs) begin
                        len[15:8] <= byte_data;
                        state     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (hs) begin
                        len[7:0] <= byte_data;
                        if (n_new == 16'd0 || {1'b0, n_new} > DEPTH17) begin
                            state <= IDLE;
                            error <= 1'b1;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (hs) begin
                        imem_wdata[15:8] <= byte_data;
                        state            <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (hs) begin
                        imem_wdata[7:0] <= byte_data;
                        state           <= WRITE;
                    end
                end
                WRITE: begin
                    cnt <= cnt + 1'b1;
                    // hold the address on the last word so it never wraps
                    if (cnt_nx == {1'b0, len}) begin
                        state <= DONE;
                    end else begin
                        imem_addr <= imem_addr + 1'b1;
                        state     <= DATA_HI;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a
// word-list reference model of the length-prefixed stream.
module tb_imem_loader;

    localparam int AW = 10;
    localparam int DP = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          busy;
    logic          cpu_hold;
    logic          done;
    logic          error;

    imem_loader #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_we = 0;
    logic [AW-1:0] got_a[$];
    logic [15:0]   got_d[$];
    logic [15:0]   words[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        #2;
        if (imem_we === 1'b1) begin
            got_a.push_back(imem_addr);
            got_d.push_back(imem_wdata);
            last_we = cyc;
            chk("ready_in_write", 32'(byte_ready), 32'd0);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        chk("hold_eq_busy", 32'(cpu_hold), 32'(busy));
    end

    task automatic send_byte(input logic [7:0] b, input bit rnd,
                             output int t);
        int guard = 0;
        @(negedge clk);
        start = 1'b0;
        if (rnd) begin
            while ($urandom_range(0, 1) == 1) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (byte_ready !== 1'b1) chk("hs_timeout", 32'd0, 32'd1);
        chk("busy_in_load", 32'(busy), 32'd1);
        t = cyc;
        @(posedge clk);
    endtask

    task automatic clear_obs();
        got_a.delete();
        got_d.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [7:0] first, input bit rnd);
        @(negedge clk);
        start      = 1'b1;
        byte_valid = !rnd;
        byte_data  = first;
        @(posedge clk);
        #1;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_clr_err", 32'(error), 32'd0);
    endtask

    task automatic check_writes(input string tag, input int nexp);
        chk({tag, "_nwr"}, 32'(got_a.size()), 32'(nexp));
        for (int i = 0; i < nexp && i < got_a.size(); i++) begin
            chk({tag, "_addr"}, 32'(got_a[i]), 32'(i));
            chk({tag, "_data"}, 32'(got_d[i]), 32'(words[i]));
        end
    endtask

    task automatic run_load(input logic [15:0] n, input bit rnd,
                            input bit tchk, input string tag);
        int t0;
        int t;
        bit bad;
        bad = (n == 16'd0) || (int'(n) > DP);
        clear_obs();
        do_start(n[15:8], rnd);
        send_byte(n[15:8], rnd, t0);
        send_byte(n[7:0], rnd, t);
        if (!bad) begin
            for (int i = 0; i < int'(n); i++) begin
                send_byte(words[i][15:8], rnd, t);
                send_byte(words[i][7:0], rnd, t);
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (8) @(negedge clk);
        #3;
        check_writes(tag, bad ? 0 : int'(n));
        chk({tag, "_done"}, 32'(done_cnt), bad ? 32'd0 : 32'd1);
        chk({tag, "_err"}, 32'(error), 32'(bad));
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        if (tchk && !bad) begin
            chk({tag, "_load_time"}, 32'(done_cyc - t0), 32'(3 * int'(n) + 2));
            chk({tag, "_done_after_we"}, 32'(done_cyc - last_we), 32'd1);
        end
    endtask

    task automatic fill_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(16'($urandom));
    endtask

    initial begin
        int t;
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", 32'(imem_wdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        words = '{16'h2603, 16'h8000};
        run_load(16'd2, 1'b0, 1'b1, "basic");

        run_load(16'd0, 1'b0, 1'b0, "len0");
        run_load(16'd1025, 1'b0, 1'b0, "len1025");

        fill_random(3);
        run_load(16'd3, 1'b1, 1'b0, "rnd3");
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 8);
            fill_random(n);
            run_load(16'(n), 1'b1, 1'b0, "rndn");
        end

        fill_random(4);
        clear_obs();
        do_start(8'h00, 1'b0);
        send_byte(8'h00, 1'b0, t);
        send_byte(8'h04, 1'b0, t);
        for (int i = 0; i < 3; i++) begin
            send_byte(words[i][15:8], 1'b0, t);
            send_byte(words[i][7:0], 1'b0, t);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        abort      = 1'b1;
        #1;
        chk("abort_suppress", 32'(imem_we), 32'd0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        repeat (6) @(negedge clk);
        #3;
        check_writes("abort", 2);
        chk("abort_err", 32'(error), 32'd1);
        chk("abort_done", 32'(done_cnt), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);

        fill_random(2);
        clear_obs();
        do_start(8'h00, 1'b0);
        send_byte(8'h00, 1'b0, t);
        send_byte(8'h02, 1'b0, t);
        send_byte(words[0][15:8], 1'b0, t);
        send_byte(words[0][7:0], 1'b0, t);
        send_byte(words[1][15:8], 1'b0, t);
        @(negedge clk);
        byte_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("mrst_ready", 32'(byte_ready), 32'd0);
        chk("mrst_we", 32'(imem_we), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_hold", 32'(cpu_hold), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_err", 32'(error), 32'd0);
        chk("mrst_addr", 32'(imem_addr), 32'd0);
        chk("mrst_wdata", 32'(imem_wdata), 32'd0);
        check_writes("mrst", 1);
        @(negedge clk);
        rst_n = 1'b1;
        words = '{16'h1234};
        run_load(16'd1, 1'b0, 1'b1, "post_rst");

        words.delete();
        for (int i = 0; i < DP; i++) words.push_back(16'(i + 16'h0100));
        run_load(16'(DP), 1'b0, 1'b1, "full");
        if (got_a.size() > 0)
            chk("full_last_addr", 32'(got_a[got_a.size()-1]), 32'(DP - 1));
        else
            chk("full_last_addr", 32'hffff_ffff, 32'(DP - 1));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory: it accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words, and drives the instruction memory write port at sequential addresses from 0. It holds the core in reset while loading and reports completion or error. It sits between the host byte link (UART/SPI receiver) and the instruction memory's write port.

## Interface
- `ADDR_W`, 10, instruction memory address width.
- `DEPTH`, 1024, instruction memory depth in words; a length above this is rejected.
- `clk` input 1 — sole clock, rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `start` input 1 — single-cycle request to begin a load; ignored unless IDLE.
- `abort` input 1 — synchronous cancel of an in-progress load.
- `byte_data` input 8 — stream byte.
- `byte_valid` input 1 — `byte_data` is valid.
- `byte_ready` output 1 — loader accepts the byte this cycle; transfer when `byte_valid && byte_ready`.
- `imem_we` output 1 — instruction memory write enable, one-cycle pulse per word.
- `imem_addr` output ADDR_W — write address.
- `imem_wdata` output 16 — write data.
- `busy` output 1 — high in every state except IDLE.
- `cpu_hold` output 1 — equals `busy`; holds the core in reset.
- `done` output 1 — one-cycle pulse on successful completion.
- `error` output 1 — sticky; set on bad length or abort, cleared by an accepted `start`.

## Operation
- Stream format: length high byte, length low byte (N, 16-bit), then N words, each as high byte then low byte.
- States:
  - IDLE: on `start`, go to LEN_HI, clear `error`, and set word counter and `imem_addr` to 0.
  - LEN_HI: capture byte into `len[15:8]`.
  - LEN_LO: capture `len[7:0]`.
    - If the resulting N is 0 or N > DEPTH, go to IDLE with `error` set. No writes occur.
    - Otherwise go to DATA_HI.
  - DATA_HI: capture `wdata[15:8]`.
  - DATA_LO: capture `wdata[7:0]`, then go to WRITE.
  - WRITE: `imem_we`=1 with current `imem_addr` and `imem_wdata`, then increment addr and count.
    - If count+1 == N, go to DONE.
    - Otherwise go to DATA_HI.
  - DONE: `done`=1 for this cycle, then IDLE.
- `byte_ready`=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO. Each of these states advances only on a handshake.
- `abort` (any non-IDLE state except DONE): go to IDLE, set `error`, and no further writes.
  - `abort` has priority over a same-cycle handshake or WRITE. A WRITE-cycle abort suppresses that write.
  - `abort` in IDLE or DONE is ignored.
- `start` and `byte_valid` together in IDLE: the byte is not consumed (`byte_ready`=0 in IDLE).
- `start` while busy: ignored; the current load continues.
- Counter is ADDR_W+1 bits so N == DEPTH completes without wrap. `imem_addr` never exceeds DEPTH-1.

## Timing
- Reset values:
  - State IDLE.
  - `byte_ready`, `imem_we`, `busy`, `cpu_hold`, `done`, `error` = 0.
  - `imem_addr`, `imem_wdata` = 0.
- Reset asserted mid-load: all outputs drop to reset values immediately (asynchronously). A partial program remains in memory.
- All outputs are registered or decoded directly from the state register. No combinational path from `byte_valid` to any output.
- `byte_ready` is a function of state only. It remains high until the handshake and is deasserted the cycle after the accepting edge if the state changes.
- Minimum per word: 3 cycles (HI, LO, WRITE).
- Minimum load time: 2 + 3N + 1 cycles from the first length byte to `done`.
- `imem_addr` and `imem_wdata` are stable throughout the `imem_we` cycle. The memory latches on the rising edge ending WRITE.
- `done` rises the cycle after the last `imem_we`. `busy` falls the cycle after `done`.

## Structure
- Shared package `imem_pkg`:
  - `IMEM_ADDR_W`=10 and `IMEM_DEPTH`=1024, also used by the instruction memory.
  - `loader_state_t` enum: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE.
- Single module with no sub-modules. The instruction memory gains a synchronous write port (`we`, `waddr`, `wdata`) on `clk` to pair with this block.

## Test plan
- `start`, then bytes 00 02 26 03 80 00 with `byte_valid` always high:
  - `imem_we` pulses write addr0=16'h2603, then addr1=16'h8000.
  - `done` pulses once, 1 cycle after the second write.
  - `busy`/`cpu_hold` high from the `start` cycle to `done`.
- Length 00 00, then length 04 01 (1025) → `error`=1, return to IDLE, zero `imem_we` pulses. Next `start` clears `error`.
- N=3 with `byte_valid` toggled randomly → identical writes and addresses; no byte is lost or duplicated, and `byte_ready` is never high in WRITE.
- N=4, `abort` asserted in the WRITE cycle of word 2 → exactly words 0,1 written, `error`=1, no `done`.
- `rst_n` low during DATA_LO of word 1 → all outputs 0 immediately. After release, a fresh N=1 load (00 01 12 34) writes addr0=16'h1234.
- N=1024 load of an incrementing pattern → last write at addr 1023 with no wrap to 0, and `done` pulses.
